// File: rtl/ssd1331_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ssd1331_cmd_sequencer
// Purpose  : Feeds the SSD1331 SPI byte transmitter. After reset it plays the
//            17-byte power-on init sequence, then expands each accepted
//            filled-rectangle request into the 11-byte 0x22 draw command and
//            holds off for DRAW_WAIT cycles while the panel accelerator runs.
//            All state advances on the falling edge of the serial clock.
// Ports    : i_SCK        serial clock (falling-edge active)
//            i_RST        asynchronous active-high reset
//            i_REQ        draw request, sampled only while o_READY=1
//            i_X0/i_X1    column start/end (saturated to 95)
//            i_Y0/i_Y1    row start/end
//            i_COLOR      RGB565 colour
//            i_TX_DONE    transmitter final-bit flag
//            o_DATA       byte to transmit
//            o_DC         data/command bit (always command)
//            o_START      one-cycle start pulse per byte
//            o_READY      idle and able to accept a request
//            o_INIT_DONE  sticky, init sequence finished
// Revision : 1.0 - initial release
// ============================================================================
module ssd1331_cmd_sequencer #(
  parameter int unsigned DRAW_WAIT = 16
) (
  input  logic        i_SCK,
  input  logic        i_RST,
  input  logic        i_REQ,
  input  logic [6:0]  i_X0,
  input  logic [6:0]  i_X1,
  input  logic [5:0]  i_Y0,
  input  logic [5:0]  i_Y1,
  input  logic [15:0] i_COLOR,
  input  logic        i_TX_DONE,
  output logic [7:0]  o_DATA,
  output logic        o_DC,
  output logic        o_START,
  output logic        o_READY,
  output logic        o_INIT_DONE
);

  localparam int HOLD_W = (DRAW_WAIT < 1) ? 1 : $clog2(DRAW_WAIT + 1);

  localparam logic [4:0]        c_init_last = 5'd16;
  localparam logic [4:0]        c_rect_last = 5'd10;
  localparam logic [6:0]        c_x_max     = 7'd95;
  localparam logic [HOLD_W-1:0] c_hold_load = HOLD_W'(DRAW_WAIT);
  localparam logic [HOLD_W-1:0] c_hold_one  = HOLD_W'(1);

  typedef enum logic [2:0] {
    S_INIT_SEND = 3'd0,
    S_INIT_WAIT = 3'd1,
    S_IDLE      = 3'd2,
    S_RECT_SEND = 3'd3,
    S_RECT_WAIT = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_idx, w_idx_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic              r_start, w_start_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_init_done, w_init_done_nxt;
  // Latched rectangle parameter bytes, already clamped/converted.
  logic [7:0]        r_x0, r_y0, r_x1, r_y1, r_cr, r_cg, r_cb;
  logic [7:0]        w_x0_nxt, w_y0_nxt, w_x1_nxt, w_y1_nxt;
  logic [7:0]        w_cr_nxt, w_cg_nxt, w_cb_nxt;

  logic [4:0]        w_idx_inc;
  logic [6:0]        w_x0_sat, w_x1_sat;

  function automatic logic [7:0] f_init_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;  // display off
      5'd1:    b = 8'hA0;  // remap / colour depth
      5'd2:    b = 8'h72;
      5'd3:    b = 8'hA1;  // start line
      5'd4:    b = 8'h00;
      5'd5:    b = 8'hA2;  // display offset
      5'd6:    b = 8'h00;
      5'd7:    b = 8'hA4;  // normal display
      5'd8:    b = 8'hA8;  // multiplex ratio
      5'd9:    b = 8'h3F;
      5'd10:   b = 8'hAD;  // master config
      5'd11:   b = 8'h8E;
      5'd12:   b = 8'hB0;  // power save
      5'd13:   b = 8'h0B;
      5'd14:   b = 8'h26;  // fill enable: rectangles are drawn filled
      5'd15:   b = 8'h01;
      5'd16:   b = 8'hAF;  // display on
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Colour triple goes out twice: outline colour, then fill colour.
  function automatic logic [7:0] f_rect_byte(
    input logic [4:0] idx,
    input logic [7:0] x0, input logic [7:0] y0,
    input logic [7:0] x1, input logic [7:0] y1,
    input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb
  );
    logic [7:0] b;
    case (idx)
      5'd0:        b = 8'h22;
      5'd1:        b = x0;
      5'd2:        b = y0;
      5'd3:        b = x1;
      5'd4:        b = y1;
      5'd5, 5'd8:  b = cr;
      5'd6, 5'd9:  b = cg;
      5'd7, 5'd10: b = cb;
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_idx_inc = r_idx + 5'd1;
  assign w_x0_sat  = (i_X0 > c_x_max) ? c_x_max : i_X0;
  assign w_x1_sat  = (i_X1 > c_x_max) ? c_x_max : i_X1;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_hold_nxt      = r_hold;
    w_data_nxt      = r_data;
    w_start_nxt     = 1'b0;
    w_ready_nxt     = r_ready;
    w_init_done_nxt = r_init_done;
    w_x0_nxt        = r_x0;
    w_y0_nxt        = r_y0;
    w_x1_nxt        = r_x1;
    w_y1_nxt        = r_y1;
    w_cr_nxt        = r_cr;
    w_cg_nxt        = r_cg;
    w_cb_nxt        = r_cb;

    case (r_state)
      S_INIT_SEND: begin
        w_data_nxt  = f_init_byte(r_idx);
        w_start_nxt = 1'b1;
        w_state_nxt = S_INIT_WAIT;
      end

      S_INIT_WAIT: begin
        if (i_TX_DONE) begin
          if (r_idx == c_init_last) begin
            w_init_done_nxt = 1'b1;
            w_ready_nxt     = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            // Next byte is launched on the same edge the done is seen.
            w_idx_nxt   = w_idx_inc;
            w_data_nxt  = f_init_byte(w_idx_inc);
            w_start_nxt = 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (i_REQ && r_ready) begin
          w_x0_nxt    = {1'b0, w_x0_sat};
          w_x1_nxt    = {1'b0, w_x1_sat};
          w_y0_nxt    = {2'b00, i_Y0};
          w_y1_nxt    = {2'b00, i_Y1};
          // RGB565 -> SSD1331 6-bit-per-channel levels.
          w_cr_nxt    = {2'b00, i_COLOR[15:11], 1'b0};
          w_cg_nxt    = {2'b00, i_COLOR[10:5]};
          w_cb_nxt    = {2'b00, i_COLOR[4:0], 1'b0};
          w_ready_nxt = 1'b0;
          w_idx_nxt   = 5'd0;
          w_data_nxt  = 8'h22;
          w_start_nxt = 1'b1;
          w_state_nxt = S_RECT_WAIT;
        end
      end

      S_RECT_SEND: begin
        w_data_nxt  = f_rect_byte(r_idx, r_x0, r_y0, r_x1, r_y1, r_cr, r_cg, r_cb);
        w_start_nxt = 1'b1;
        w_state_nxt = S_RECT_WAIT;
      end

      S_RECT_WAIT: begin
        if (i_TX_DONE) begin
          if (r_idx == c_rect_last) begin
            if (DRAW_WAIT == 0) begin
              w_ready_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_hold_nxt  = c_hold_load;
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_data_nxt  = f_rect_byte(w_idx_inc, r_x0, r_y0, r_x1, r_y1, r_cr, r_cg, r_cb);
            w_start_nxt = 1'b1;
          end
        end
      end

      S_HOLD: begin
        // Ready is raised on the edge where the count would reach zero.
        if (r_hold <= c_hold_one) begin
          w_hold_nxt  = '0;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = r_hold - c_hold_one;
        end
      end

      default: begin
        w_state_nxt = S_INIT_SEND;
        w_idx_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(negedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      r_state     <= S_INIT_SEND;
      r_idx       <= 5'd0;
      r_hold      <= '0;
      r_data      <= 8'h00;
      r_start     <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_x0        <= 8'h00;
      r_y0        <= 8'h00;
      r_x1        <= 8'h00;
      r_y1        <= 8'h00;
      r_cr        <= 8'h00;
      r_cg        <= 8'h00;
      r_cb        <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_hold      <= w_hold_nxt;
      r_data      <= w_data_nxt;
      r_start     <= w_start_nxt;
      r_ready     <= w_ready_nxt;
      r_init_done <= w_init_done_nxt;
      r_x0        <= w_x0_nxt;
      r_y0        <= w_y0_nxt;
      r_x1        <= w_x1_nxt;
      r_y1        <= w_y1_nxt;
      r_cr        <= w_cr_nxt;
      r_cg        <= w_cg_nxt;
      r_cb        <= w_cb_nxt;
    end
  end

  assign o_DATA      = r_data;
  assign o_DC        = 1'b0;
  assign o_START     = r_start;
  assign o_READY     = r_ready;
  assign o_INIT_DONE = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd1331_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd1331_cmd_sequencer
// Purpose  : Self-checking bench for ssd1331_cmd_sequencer with a behavioural
//            SPI transmitter (done seen 9 edges after each start pulse).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd1331_cmd_sequencer;

  logic        i_SCK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_REQ = 1'b0;
  logic [6:0]  i_X0 = 7'd0;
  logic [6:0]  i_X1 = 7'd0;
  logic [5:0]  i_Y0 = 6'd0;
  logic [5:0]  i_Y1 = 6'd0;
  logic [15:0] i_COLOR = 16'h0000;
  logic        i_TX_DONE = 1'b0;
  logic [7:0]  o_DATA;
  logic        o_DC;
  logic        o_START;
  logic        o_READY;
  logic        o_INIT_DONE;

  ssd1331_cmd_sequencer #(.DRAW_WAIT(16)) dut (
    .i_SCK(i_SCK), .i_RST(i_RST), .i_REQ(i_REQ),
    .i_X0(i_X0), .i_X1(i_X1), .i_Y0(i_Y0), .i_Y1(i_Y1),
    .i_COLOR(i_COLOR), .i_TX_DONE(i_TX_DONE),
    .o_DATA(o_DATA), .o_DC(o_DC), .o_START(o_START),
    .o_READY(o_READY), .o_INIT_DONE(o_INIT_DONE)
  );

  always #5 i_SCK = ~i_SCK;

  int checks = 0;
  int errors = 0;

  int         edge_cnt = 0;
  int         tx_cnt   = 0;
  int         stall_at = -1;
  logic       in_stall = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] cap_data[$];
  int         cap_edge[$];

  logic [0:16][7:0] rom_exp = {8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
                               8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'h26, 8'h01, 8'hAF};

  typedef struct packed {
    logic [6:0]       x0;
    logic [5:0]       y0;
    logic [6:0]       x1;
    logic [5:0]       y1;
    logic [15:0]      color;
    logic [0:10][7:0] exp;
    int               stall_byte;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: rectangle command from the panel's rules, plain arithmetic.
  function automatic logic [0:10][7:0] model_rect(input int x0, input int y0, input int x1,
                                                   input int y1, input int color);
    logic [0:10][7:0] e;
    int cx0, cx1, r, g, b;
    cx0 = (x0 > 95) ? 95 : x0;
    cx1 = (x1 > 95) ? 95 : x1;
    r = (color / 2048) % 32;
    g = (color / 32) % 64;
    b = color % 32;
    e[0] = 8'h22;
    e[1] = 8'(cx0);
    e[2] = 8'(y0);
    e[3] = 8'(cx1);
    e[4] = 8'(y1);
    for (int k = 0; k < 2; k++) begin
      e[5 + 3*k] = 8'(r * 2);
      e[6 + 3*k] = 8'(g);
      e[7 + 3*k] = 8'(b * 2);
    end
    return e;
  endfunction

  // Transmitter model and byte monitor, evaluated just after each active edge.
  always @(negedge i_SCK) begin
    #1;
    if (i_RST) begin
      edge_cnt  = 0;
      tx_cnt    = 0;
      i_TX_DONE = 1'b0;
      in_stall  = 1'b0;
      last_data = 8'h00;
    end else begin
      edge_cnt++;
      if (i_TX_DONE) i_TX_DONE = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_TX_DONE = 1'b1;
          in_stall  = 1'b0;
        end
      end
      if (o_START) begin
        chk("start_while_busy", 32'(tx_cnt), 32'd0);
        chk("dc_bit", 32'(o_DC), 32'd0);
        cap_data.push_back(o_DATA);
        cap_edge.push_back(edge_cnt);
        last_data = o_DATA;
        if (cap_data.size() - 1 == stall_at) begin
          tx_cnt   = 8 + 50;
          in_stall = 1'b1;
        end else begin
          tx_cnt = 8;
        end
      end else begin
        chk(in_stall ? "stall_data_hold" : "data_hold", 32'(o_DATA), 32'(last_data));
      end
    end
  end

  task automatic check_init(input string tag);
    int base, got;
    base = cap_data.size();
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_SCK); #2;
      i_REQ = (edge_cnt >= 20 && edge_cnt < 30);
      if (edge_cnt == 153) chk({tag, "_init_done_early"}, 32'(o_INIT_DONE), 32'd0);
      if (o_READY) begin got = 1; break; end
    end
    i_REQ = 1'b0;
    chk({tag, "_ready_timeout"}, 32'(got), 32'd1);
    chk({tag, "_ready_edge"}, 32'(edge_cnt), 32'd154);
    chk({tag, "_init_done"}, 32'(o_INIT_DONE), 32'd1);
    chk({tag, "_byte_count"}, 32'(cap_data.size() - base), 32'd17);
    for (int k = 0; k < 17; k++) begin
      if (base + k < cap_data.size()) begin
        chk($sformatf("%s_byte%0d", tag, k), 32'(cap_data[base + k]), 32'(rom_exp[k]));
        chk($sformatf("%s_edge%0d", tag, k), 32'(cap_edge[base + k]), 32'(1 + 9*k));
      end
    end
  endtask

  task automatic do_rect(input string tag, input logic [6:0] x0, input logic [5:0] y0,
                         input logic [6:0] x1, input logic [5:0] y1, input logic [15:0] col,
                         input logic [0:10][7:0] exp, input int sb, input int gap);
    int base, r, hs, add, got, want;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      if (o_READY) begin got = 1; break; end
      @(negedge i_SCK); #2;
    end
    chk({tag, "_ready_wait"}, 32'(got), 32'd1);
    repeat (gap) begin @(negedge i_SCK); #2; end
    base = cap_data.size();
    stall_at = (sb >= 0) ? base + sb : -1;
    add = (sb >= 0) ? 50 : 0;
    i_X0 = x0; i_Y0 = y0; i_X1 = x1; i_Y1 = y1; i_COLOR = col;
    i_REQ = 1'b1;
    @(negedge i_SCK); #2;
    i_REQ = 1'b0;
    r = edge_cnt;
    chk({tag, "_accept_start"}, 32'(o_START), 32'd1);
    chk({tag, "_accept_ready"}, 32'(o_READY), 32'd0);
    hs = r + 99 + add;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_SCK); #2;
      if (o_READY) begin got = 1; break; end
      // Requests during HOLD must be ignored.
      i_REQ = (edge_cnt >= hs + 2 && edge_cnt < hs + 8);
    end
    i_REQ = 1'b0;
    stall_at = -1;
    chk({tag, "_done_timeout"}, 32'(got), 32'd1);
    chk({tag, "_ready_edge"}, 32'(edge_cnt), 32'(hs + 16));
    chk({tag, "_init_done_sticky"}, 32'(o_INIT_DONE), 32'd1);
    chk({tag, "_byte_count"}, 32'(cap_data.size() - base), 32'd11);
    for (int k = 0; k < 11; k++) begin
      if (base + k < cap_data.size()) begin
        want = r + 9*k + ((sb >= 0 && k > sb) ? 50 : 0);
        chk($sformatf("%s_byte%0d", tag, k), 32'(cap_data[base + k]), 32'(exp[k]));
        chk($sformatf("%s_edge%0d", tag, k), 32'(cap_edge[base + k]), 32'(want));
      end
    end
  endtask

  initial begin
    tbl[0] = '{x0: 7'd2,   y0: 6'd3, x1: 7'd50, y1: 6'd40, color: 16'hF800,
               exp: 88'h22_02_03_32_28_3E_00_00_3E_00_00, stall_byte: -1};
    tbl[1] = '{x0: 7'd0,   y0: 6'd0, x1: 7'd120, y1: 6'd63, color: 16'h07FF,
               exp: 88'h22_00_00_5F_3F_00_3F_3E_00_3F_3E, stall_byte: 3};
    tbl[2] = '{x0: 7'd100, y0: 6'd5, x1: 7'd10, y1: 6'd60, color: 16'h001F,
               exp: 88'h22_5F_05_0A_3C_00_00_3E_00_00_3E, stall_byte: -1};

    #2;
    chk("rst_data", 32'(o_DATA), 32'h00);
    chk("rst_dc", 32'(o_DC), 32'd0);
    chk("rst_start", 32'(o_START), 32'd0);
    chk("rst_ready", 32'(o_READY), 32'd0);
    chk("rst_init_done", 32'(o_INIT_DONE), 32'd0);
    @(negedge i_SCK); @(negedge i_SCK); #3;
    i_RST = 1'b0;

    check_init("init");

    for (int v = 0; v < 3; v++)
      do_rect($sformatf("vec%0d", v), tbl[v].x0, tbl[v].y0, tbl[v].x1, tbl[v].y1,
              tbl[v].color, tbl[v].exp, tbl[v].stall_byte, v);

    // Reset while byte 5 of a rectangle is being launched.
    begin
      int base, got;
      base = cap_data.size();
      i_X0 = 7'd2; i_Y0 = 6'd3; i_X1 = 7'd50; i_Y1 = 6'd40; i_COLOR = 16'hF800;
      i_REQ = 1'b1;
      @(negedge i_SCK); #2;
      i_REQ = 1'b0;
      got = 0;
      for (int i = 0; i < 100; i++) begin
        if (cap_data.size() >= base + 6) begin got = 1; break; end
        @(negedge i_SCK); #2;
      end
      chk("midrst_reach_byte5", 32'(got), 32'd1);
      i_RST = 1'b1;
      #1;
      chk("midrst_data", 32'(o_DATA), 32'h00);
      chk("midrst_dc", 32'(o_DC), 32'd0);
      chk("midrst_start", 32'(o_START), 32'd0);
      chk("midrst_ready", 32'(o_READY), 32'd0);
      chk("midrst_init_done", 32'(o_INIT_DONE), 32'd0);
      @(negedge i_SCK); @(negedge i_SCK); #3;
      i_RST = 1'b0;
      check_init("reinit");
    end

    for (int n = 0; n < 6; n++) begin
      int x0, y0, x1, y1, col;
      x0  = int'($urandom_range(0, 127));
      x1  = int'($urandom_range(0, 127));
      y0  = int'($urandom_range(0, 63));
      y1  = int'($urandom_range(0, 63));
      col = int'($urandom_range(0, 65535));
      do_rect($sformatf("rnd%0d", n), 7'(x0), 6'(y0), 7'(x1), 6'(y1), 16'(col),
              model_rect(x0, y0, x1, y1, col), -1, int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
